// File: rtl/serial_mult_pkg.sv
// Shared definitions for the bit-serial multiplier: FSM state codes and sizing helpers.
package serial_mult_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ADD   = 2'd1;
    localparam state_t ST_SHIFT = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    // Accept-to-valid latency when every iteration runs all of its add cycles.
    function automatic int lat_fixed(input int w);
        return w * (w + 1);
    endfunction

    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/fulladder.sv
// One-bit full adder; the multiplier's only adding element.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_mult_ctrl.sv
// Bit-serial shift-and-add unsigned multiplier built around a single full adder.
// Optional build macro SERIAL_MULT_SKIP_ZERO_EN skips the add pass for multiplier bits that are 0.
module serial_mult_ctrl
    import serial_mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic               busy
);

    localparam int CNT_W = cnt_w(WIDTH);

`ifdef SERIAL_MULT_SKIP_ZERO_EN
    localparam bit SKIP_ZERO = 1'b1;
`else
    localparam bit SKIP_ZERO = 1'b0;
`endif

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_h;
    logic [WIDTH-1:0]   r_l;
    logic               r_c;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [CNT_W-1:0]   r_it_cnt;
    logic [2*WIDTH-1:0] r_out_p;

    logic             w_sum;
    logic             w_cout;
    logic [WIDTH-1:0] w_h_shift;
    logic [WIDTH-1:0] w_l_shift;

    fulladder u_fa (
        .a    (r_h[0]),
        .b    (r_a[0] & r_l[0]),
        .cin  (r_c),
        .s    (w_sum),
        .cout (w_cout)
    );

    // {c,H,L} >> 1 with a zero shifted in above the carry; written with shifts so WIDTH=1 works.
    assign w_h_shift = (r_h >> 1) | (WIDTH'(r_c)    << (WIDTH - 1));
    assign w_l_shift = (r_l >> 1) | (WIDTH'(r_h[0]) << (WIDTH - 1));

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_a       <= '0;
            r_h       <= '0;
            r_l       <= '0;
            r_c       <= 1'b0;
            r_bit_cnt <= '0;
            r_it_cnt  <= '0;
            r_out_p   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a       <= in_a;
                        r_h       <= '0;
                        r_l       <= in_b;
                        r_c       <= 1'b0;
                        r_bit_cnt <= '0;
                        r_it_cnt  <= '0;
                        r_state   <= (SKIP_ZERO && !in_b[0]) ? ST_SHIFT : ST_ADD;
                    end
                end
                ST_ADD: begin
                    r_h       <= (r_h >> 1) | (WIDTH'(w_sum) << (WIDTH - 1));
                    r_a       <= (r_a >> 1) | (r_a << (WIDTH - 1));
                    r_c       <= w_cout;
                    r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    if (r_bit_cnt == CNT_W'(WIDTH - 1)) begin
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_h       <= w_h_shift;
                    r_l       <= w_l_shift;
                    r_c       <= 1'b0;
                    r_bit_cnt <= '0;
                    r_it_cnt  <= r_it_cnt + CNT_W'(1);
                    if (r_it_cnt == CNT_W'(WIDTH - 1)) begin
                        r_out_p <= {w_h_shift, w_l_shift};
                        r_state <= ST_DONE;
                    end else begin
                        r_state <= (SKIP_ZERO && !w_l_shift[0]) ? ST_SHIFT : ST_ADD;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state == ST_ADD) || (r_state == ST_SHIFT);
    assign out_p     = r_out_p;

endmodule
